// File: rtl/cfu_requant_pkg.sv
// Shared constants, per-channel parameter record and the fixed-point helpers
// used by the requantizer datapath and its golden-model checks.
package cfu_requant_pkg;

  localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
  localparam logic signed [31:0] INT32_MAX = 32'sh7fff_ffff;
  localparam logic signed [63:0] NUDGE_POS = 64'sd1073741824;
  localparam logic signed [63:0] NUDGE_NEG = -64'sd1073741823;

  typedef struct packed {
    logic signed [31:0] bias;
    logic signed [31:0] mul;
    logic signed [5:0]  shift;
  } chan_param_t;

  // Rounded high half of a Q31 product; the bias term turns the arithmetic
  // shift (floor) into a divide that truncates toward zero.
  function automatic logic signed [31:0] srdhm(input logic signed [63:0] ab,
                                               input logic sat);
    logic signed [63:0] s;
    logic signed [63:0] t;
    s = ab + ((ab >= 0) ? NUDGE_POS : NUDGE_NEG);
    t = s + ((s < 0) ? 64'sd2147483647 : 64'sd0);
    t = t >>> 31;
    return sat ? INT32_MAX : t[31:0];
  endfunction

  // Divide by 2^rs, rounding half away from zero.
  function automatic logic signed [31:0] rounding_rshift(input logic signed [31:0] h,
                                                         input logic [4:0] rs);
    logic [31:0]        mask;
    logic [31:0]        rem;
    logic [31:0]        thr;
    logic signed [31:0] q;
    mask = (32'd1 << rs) - 32'd1;
    rem  = h & mask;
    thr  = (mask >> 1) + {31'd0, h[31]};
    q    = h >>> rs;
    if (rs == 5'd0) return h;
    return q + ((rem > thr) ? 32'sd1 : 32'sd0);
  endfunction

endpackage

// File: rtl/cfu_requant_lane.sv
// One lane of the requantizer: bias/shift, Q31 multiply, rounding right
// shift, zero point and clamp, one register stage each, all gated by i_en.
module cfu_requant_lane
  import cfu_requant_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic signed [31:0]  i_acc,
  input  logic signed [31:0]  i_bias,
  input  logic signed [31:0]  i_mul,
  input  logic signed [5:0]   i_shift,
  input  logic signed [31:0]  i_offset,
  input  logic signed [31:0]  i_min,
  input  logic signed [31:0]  i_max,
  output logic [OUT_W-1:0]    o_data
);

  logic signed [31:0] w_sum;
  logic [4:0]         w_ls;
  logic [4:0]         w_rs;
  logic signed [63:0] w_ab;
  logic [OUT_W-1:0]   w_out;

  logic signed [31:0] r_x1;
  logic signed [31:0] r_mul1;
  logic [4:0]         r_rs1;
  logic signed [63:0] r_ab2;
  logic               r_sat2;
  logic [4:0]         r_rs2;
  logic signed [31:0] r_r3;
  logic [OUT_W-1:0]   r_out;

  function automatic logic [OUT_W-1:0] clamp_trunc(input logic signed [31:0] y,
                                                   input logic signed [31:0] mn,
                                                   input logic signed [31:0] mx);
    logic signed [31:0] c;
    c = (y < mn) ? mn : ((y > mx) ? mx : y);
    return c[OUT_W-1:0];
  endfunction

  always_comb begin
    w_sum = i_acc + i_bias;
    w_ls  = i_shift[5] ? '0 : i_shift[4:0];
    w_rs  = i_shift[5] ? 5'(-i_shift) : '0;
    w_ab  = $signed({{32{r_x1[31]}}, r_x1}) * $signed({{32{r_mul1[31]}}, r_mul1});
    w_out = clamp_trunc(r_r3 + i_offset, i_min, i_max);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x1   <= '0;
      r_mul1 <= '0;
      r_rs1  <= '0;
      r_ab2  <= '0;
      r_sat2 <= 1'b0;
      r_rs2  <= '0;
      r_r3   <= '0;
      r_out  <= '0;
    end else if (i_en) begin
      r_x1   <= w_sum << w_ls;
      r_mul1 <= i_mul;
      r_rs1  <= w_rs;
      r_ab2  <= w_ab;
      r_sat2 <= (r_x1 == INT32_MIN) && (r_mul1 == INT32_MIN);
      r_rs2  <= r_rs1;
      r_r3   <= rounding_rshift(srdhm(r_ab2, r_sat2), r_rs2);
      r_out  <= w_out;
    end
  end

  assign o_data = r_out;

endmodule

// File: rtl/cfu_requant_pipe.sv
// Streaming multi-lane int32 -> intN requantizer: per-channel parameter table,
// auto-advancing channel pointer, capture stage plus LANES x 4-stage datapath.
module cfu_requant_pipe
  import cfu_requant_pkg::*;
#(
  parameter  int LANES    = 4,
  parameter  int ACC_W    = 32,
  parameter  int OUT_W    = 8,
  parameter  int CH_DEPTH = 64,
  localparam int CH_AW    = $clog2(CH_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [CH_AW-1:0]        cfg_addr,
  input  logic signed [ACC_W-1:0] cfg_bias,
  input  logic signed [ACC_W-1:0] cfg_mul,
  input  logic signed [5:0]       cfg_shift,
  input  logic                    per_chan,
  input  logic [CH_AW:0]          num_ch,
  input  logic                    chan_clr,
  input  logic signed [ACC_W-1:0] offset,
  input  logic signed [ACC_W-1:0] min,
  input  logic signed [ACC_W-1:0] max,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*ACC_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*OUT_W-1:0]  out_data,
  output logic                    busy
);

  chan_param_t      r_tab [CH_DEPTH];
  logic [4:0]       r_vld;
  logic [CH_AW-1:0] r_ptr;
  logic [CH_AW:0]   r_nch;
  logic             w_adv;
  logic             w_acc;

  // (base + inc) mod n for inc < n + LANES; a short chain of conditional
  // subtractions replaces a general modulo.
  function automatic logic [CH_AW-1:0] wrap_add(input logic [CH_AW-1:0] base,
                                                input logic [CH_AW+3:0] inc,
                                                input logic [CH_AW:0]   n);
    logic [CH_AW+3:0] v;
    v = {4'b0, base} + inc;
    for (int unsigned k = 0; k <= LANES; k++) begin
      if (v >= {3'b0, n}) v = v - {3'b0, n};
    end
    return v[CH_AW-1:0];
  endfunction

  assign w_adv     = out_ready || !out_valid;
  assign w_acc     = in_valid && w_adv;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[4];
  assign busy      = |r_vld;

  always_ff @(posedge clk) begin
    if (cfg_we) r_tab[cfg_addr] <= '{bias: cfg_bias, mul: cfg_mul, shift: cfg_shift};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
    end else if (w_adv) begin
      r_vld <= {r_vld[3:0], w_acc};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      r_nch <= (CH_AW+1)'(1);
    end else if (chan_clr) begin
      r_ptr <= '0;
      r_nch <= num_ch;
    end else if (w_acc) begin
      r_ptr <= wrap_add(r_ptr, (CH_AW+4)'(LANES), r_nch);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [CH_AW-1:0]   w_ch;
    logic signed [31:0] r_acc;
    chan_param_t        r_par;

    assign w_ch = per_chan ? wrap_add(r_ptr, (CH_AW+4)'(g), r_nch) : '0;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_acc <= '0;
        r_par <= '0;
      end else if (w_acc) begin
        r_acc <= in_data[ACC_W*g +: ACC_W];
        r_par <= r_tab[w_ch];
      end
    end

    cfu_requant_lane #(.OUT_W(OUT_W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_en     (w_adv),
      .i_acc    (r_acc),
      .i_bias   (r_par.bias),
      .i_mul    (r_par.mul),
      .i_shift  (r_par.shift),
      .i_offset (offset),
      .i_min    (min),
      .i_max    (max),
      .o_data   (out_data[OUT_W*g +: OUT_W])
    );
  end

  a_shift_range: assert property (@(posedge clk) disable iff (rst)
    cfg_we |-> (cfg_shift != 6'b10_0000));

endmodule

// File: tb/tb_cfu_requant_pipe.sv
// Self-checking bench for cfu_requant_pipe: behavioural model plus stream
// comparator, with hand-computed vectors pinning the model.
module tb_cfu_requant_pipe;
  localparam int LANES    = 4;
  localparam int OUT_W    = 8;
  localparam int CH_DEPTH = 64;
  localparam int CH_AW    = 6;
  localparam int INT_MIN  = 32'h8000_0000;

  logic              clk;
  logic              rst;
  logic              cfg_we;
  logic [CH_AW-1:0]  cfg_addr;
  logic [31:0]       cfg_bias;
  logic [31:0]       cfg_mul;
  logic [5:0]        cfg_shift;
  logic              per_chan;
  logic [CH_AW:0]    num_ch;
  logic              chan_clr;
  logic [31:0]       offset_v;
  logic [31:0]       min_v;
  logic [31:0]       max_v;
  logic              in_valid;
  logic              in_ready;
  logic [127:0]      in_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic              busy;

  cfu_requant_pipe #(.LANES(LANES), .ACC_W(32), .OUT_W(OUT_W), .CH_DEPTH(CH_DEPTH)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_bias(cfg_bias),
    .cfg_mul(cfg_mul), .cfg_shift(cfg_shift), .per_chan(per_chan), .num_ch(num_ch),
    .chan_clr(chan_clr), .offset(offset_v), .min(min_v), .max(max_v),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  int m_bias [CH_DEPTH];
  int m_mul  [CH_DEPTH];
  int m_sh   [CH_DEPTH];
  int m_ptr  = 0;
  int m_nch  = 1;
  logic [31:0] exp_q [$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_round(input int h, input int rs);
    longint d, q, rm;
    if (rs == 0) return h;
    d  = longint'(1) << rs;
    q  = longint'(h) / d;
    rm = longint'(h) - q * d;
    if (rm < 0) rm = -rm;
    if (2 * rm >= d) q = (h < 0) ? q - 1 : q + 1;
    return int'(q);
  endfunction

  function automatic logic [7:0] model_lane(input int acc, input int bias, input int mul,
                                            input int sh, input int off, input int mn, input int mx);
    int x, hi, r, y, rs;
    longint ab, h, nudge;
    x  = acc + bias;
    if (sh > 0) x = x << sh;
    rs = (sh < 0) ? -sh : 0;
    if (x == INT_MIN && mul == INT_MIN) begin
      h = 64'sd2147483647;
    end else begin
      ab    = longint'(x) * longint'(mul);
      nudge = (ab >= 0) ? 64'sd1073741824 : -64'sd1073741823;
      h     = (ab + nudge) / 64'sd2147483648;
    end
    hi = int'(h);
    r  = model_round(hi, rs);
    y  = r + off;
    if (y < mn) y = mn;
    if (y > mx) y = mx;
    return y[7:0];
  endfunction

  function automatic logic [31:0] model_beat(input logic [127:0] d);
    logic [31:0] res;
    int ch;
    res = '0;
    for (int i = 0; i < LANES; i++) begin
      ch = per_chan ? (m_ptr + i) % m_nch : 0;
      res[8*i +: 8] = model_lane(int'(d[32*i +: 32]), m_bias[ch], m_mul[ch], m_sh[ch],
                                 int'(offset_v), int'(min_v), int'(max_v));
    end
    return res;
  endfunction

  // Model update and stream comparison, sampled late in each cycle.
  always @(negedge clk) begin
    #3;
    if (rst) begin
      exp_q.delete();
      m_ptr      = 0;
      m_nch      = 1;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %h expected none at %0t", out_data, $time);
        end else begin
          check("stream", out_data, exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (in_valid && in_ready) begin
        exp_q.push_back(model_beat(in_data));
        m_ptr = (m_ptr + LANES) % m_nch;
      end
      if (chan_clr) begin
        m_ptr = 0;
        m_nch = int'(num_ch);
      end
      if (cfg_we) begin
        m_bias[cfg_addr] = int'(cfg_bias);
        m_mul[cfg_addr]  = int'(cfg_mul);
        m_sh[cfg_addr]   = int'($signed(cfg_shift));
      end
    end
  end

  task automatic cfg_write(input int a, input int b, input int m, input int s);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = CH_AW'(a);
    cfg_bias  = b;
    cfg_mul   = m;
    cfg_shift = 6'(s);
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic single(input int acc, input int bias, input int mul, input int sh,
                        input logic [7:0] expv, input string nm);
    int lat;
    cfg_write(0, bias, mul, sh);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {4{acc}};
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat = k;
    end
    check({nm, "_latency"}, lat, 4);
    check(nm, out_data, {4{expv}});
  endtask

  task automatic collect3(output logic [31:0] g0, output logic [31:0] g1, output logic [31:0] g2);
    logic [31:0] got [3];
    int n;
    n = 0;
    got[0] = '0; got[1] = '0; got[2] = '0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid && n < 3) begin
        got[n] = out_data;
        n++;
      end
    end
    g0 = got[0]; g1 = got[1]; g2 = got[2];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g0, g1, g2;
    int spur, sent, cyc, n0;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_bias = '0; cfg_mul = '0; cfg_shift = '0;
    per_chan = 1'b0; num_ch = 7'd1; chan_clr = 1'b0;
    offset_v = -128; min_v = -128; max_v = 127;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_data", out_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // model pinned to hand-computed values
    check("model_T1a", {24'd0, model_lane(-16113, 18377, 1459272781, -8, -128, -128, 127)}, 32'h86);
    check("model_T4a", {24'd0, model_lane(INT_MIN, 0, INT_MIN, 0, -128, -128, 127)}, 32'h7F);
    check("model_round_a", model_round(-12, 3), -2);
    check("model_round_b", model_round(12, 3), 2);
    check("model_round_c", model_round(-20, 3), -3);

    // T1
    single(-16113, 18377, 1459272781, -8, 8'h86, "T1a");
    single(-17704, -13074, 1201775990, -9, 8'h80, "T1b");
    single(8918, 18642, 2061439064, -9, 8'hB4, "T1c");
    // T4
    single(INT_MIN, 0, INT_MIN, 0, 8'h7F, "T4_sat");
    single(1, 0, 32'h4000_0000, 3, 8'h84, "T4_lshift");
    // T5
    offset_v = 0;
    single(-24, 0, 32'h4000_0000, -3, 8'hFE, "T5_neg12");
    single(24, 0, 32'h4000_0000, -3, 8'h02, "T5_pos12");
    single(-40, 0, 32'h4000_0000, -3, 8'hFD, "T5_neg20");

    // T2
    for (int c = 0; c < 6; c++) cfg_write(c, 0, (c + 1) << 27, 0);
    per_chan = 1'b1;
    num_ch   = 7'd6;
    @(negedge clk); chan_clr = 1'b1;
    @(negedge clk); chan_clr = 1'b0;
    in_valid = 1'b1;
    in_data  = {4{32'd256}};
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    collect3(g0, g1, g2);
    check("T2_beat0", g0, 32'h40302010);
    check("T2_beat1", g1, 32'h20106050);
    check("T2_beat2", g2, 32'h60504030);

    // T6
    @(negedge clk); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    repeat (8) @(negedge clk);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("T6_pre_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("T6_valid_drop", {31'd0, out_valid}, 32'd0);
    check("T6_busy_drop", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    spur = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) spur++;
    end
    check("T6_no_stale", spur, 0);
    @(negedge clk); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    collect3(g0, g1, g2);
    check("T6_ptr_reset", g0, 32'h10101010);

    // T3
    offset_v = 3; min_v = -100; max_v = 90;
    for (int c = 0; c < 5; c++)
      cfg_write(c, int'($urandom), int'($urandom), int'($urandom_range(62, 0)) - 31);
    num_ch = 7'd5;
    @(negedge clk); chan_clr = 1'b1;
    @(negedge clk); chan_clr = 1'b0;
    n0 = n_out; sent = 0; cyc = 0;
    while (sent < 200 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'($urandom_range(1, 0));
      in_valid  = ($urandom_range(3, 0) != 0);
      for (int i = 0; i < LANES; i++) in_data[32*i +: 32] = $urandom;
      chan_clr  = (cyc == 150);
      #1;
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0; chan_clr = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (!busy) break;
      @(negedge clk);
    end
    @(negedge clk);
    check("T3_beats_out", n_out - n0, 200);
    check("T3_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
